banco_registros_arbitro: RTL and testbench
==========================================

// Module: banco_registros_arbitro
// PURPOSE
// - Arbitrates the single write port of the 32x32 register file (banco_registros) between two writeback requesters:
//   A = ALU writeback, B = memory/load writeback.
// - Round-robin grant with a valid/ready handshake per requester.
// - One registered output stage drives WA/dataIn/WE of the register file, so writes are glitch-free and clock-aligned.
// PARAMETERS
// - AW          5   register address width (32 registers)
// - DW          32  data width
// - R0_WRITABLE 1   1: writes to address 0 pass through; 0: accepted and acked but rf_we held low
// PORTS
// - clk          in   1   clock, rising edge
// - rst_n        in   1   asynchronous reset, active low
// - a_valid      in   1   requester A has a write pending
// - a_addr       in   AW  requester A destination register
// - a_data       in   DW  requester A write data
// - a_ready      out  1   A accepted this cycle (combinational grant)
// - b_valid      in   1   requester B has a write pending
// - b_addr       in   AW  requester B destination register
// - b_data       in   DW  requester B write data
// - b_ready      out  1   B accepted this cycle (combinational grant)
// - rf_wa        out  AW  to banco_registros WA
// - rf_data      out  DW  to banco_registros dataIn
// - rf_we        out  1   to banco_registros WE
// - conflict_cnt out  16  contested-cycle counter (only with RF_ARB_CONFLICT_CNT_EN)
// BEHAVIOUR
// - Transfer: X_valid & X_ready at a rising clk edge. Requester holds addr/data stable while valid & !ready.
// - Grant, combinational, exactly one per cycle:
//   - only A valid -> A; only B valid -> B
//   - both valid -> the side indicated by prio (prio=0: A, prio=1: B)
// - prio register:
//   - after an A transfer prio<=1; after a B transfer prio<=0
//   - unchanged when neither transfers
//   - reset value 0 (A favoured)
// - Output stage:
//   - on a transfer: rf_wa<=addr, rf_data<=data, rf_we<=1 (0 if addr==0 and R0_WRITABLE==0)
//   - otherwise rf_we<=0; rf_wa/rf_data hold their previous values
// - Latency: accept at edge N -> rf_we high during cycle N+1 for exactly one cycle.
// - Throughput: one write per cycle. Under continuous contention A and B alternate, so each waits at most 1 cycle.
// - Same address on both sides, both valid: only the granted side writes. The loser writes the next cycle (last writer wins).
// - Reset (async, rst_n=0):
//   - rf_we=0, rf_wa=0, rf_data=0, prio=0, conflict_cnt=0 immediately
//   - a_ready=b_ready=0 while rst_n=0
//   - an in-flight registered write is dropped; requesters keep valid and are re-arbitrated after release
// - No backpressure from the register file: its write always completes in one cycle.
// CONFIGURATION
// - Macro RF_ARB_CONFLICT_CNT_EN.
// - Defined:
//   - conflict_cnt increments on every cycle with a_valid & b_valid (rst_n=1)
//   - saturates at 16'hFFFF
// - Undefined: counter logic not built; conflict_cnt tied to 0. Arbitration unchanged.
// TESTING
// - Reset: rst_n=0 mid-write (rf_we=1) -> rf_we=0 same cycle, no write. After release, A valid addr=3 -> write occurs.
// - Single: A valid addr=5 data=32'hDEADBEEF -> a_ready=1; next cycle rf_we=1, rf_wa=5, rf_data=DEADBEEF; then rf_we=0.
// - Contention after reset: A(addr=1,data=11) and B(addr=2,data=22) both valid 4 cycles:
//   - grant order A,B,A,B
//   - rf_wa sequence 1,2,1,2 one cycle late
//   - conflict_cnt=4 with macro, 0 without
// - Same address: A(addr=7,data=1) and B(addr=7,data=2) with prio=0 -> rf_we cycles write 1 then 2; register 7 ends =2.
// - R0: R0_WRITABLE=0, B addr=0 data=9 -> b_ready=1, rf_we stays 0. R0_WRITABLE=1 -> rf_we=1, rf_wa=0.
// - Saturation (macro on): force 70000 contested cycles -> conflict_cnt=16'hFFFF, no wrap.

Source files
------------

// File: rtl/banco_registros_arbitro_if.sv
// Write-port bus between the two writeback requesters, the arbiter and the register file.
// Carries both request channels, the registered register-file write port and the conflict counter.
interface banco_registros_arbitro_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic          a_valid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          a_ready;

  logic          b_valid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          b_ready;

  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_data;
  logic          rf_we;
  logic [15:0]   conflict_cnt;

  // Requesters / environment side
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, rf_wa, rf_data, rf_we, conflict_cnt
  );

  // Arbiter side
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, rf_wa, rf_data, rf_we, conflict_cnt
  );
endinterface

// File: rtl/banco_registros_arbitro.sv
// Round-robin arbiter for the single write port of the 32x32 register file (ALU vs. load writeback).
// Optional contested-cycle counter built only when RF_ARB_CONFLICT_CNT_EN is defined.
module banco_registros_arbitro #(
  parameter int unsigned AW          = 5,
  parameter int unsigned DW          = 32,
  parameter bit          R0_WRITABLE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  banco_registros_arbitro_if.slave  bus
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_e;

  prio_e         prio_q, prio_d;
  logic          grant_a, grant_b;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          we_q;
  logic [AW-1:0] wa_q;
  logic [DW-1:0] data_q;

  // Priority state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= PRIO_A;
    else        prio_q <= prio_d;
  end

  // Grant, next priority and write-path mux; nothing is granted while in reset
  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    prio_d   = prio_q;
    sel_addr = bus.a_addr;
    sel_data = bus.a_data;
    if (rst_n) begin
      if (bus.a_valid && (!bus.b_valid || prio_q == PRIO_A)) grant_a = 1'b1;
      else if (bus.b_valid)                                   grant_b = 1'b1;
    end
    if (grant_a) begin
      prio_d = PRIO_B;
    end else if (grant_b) begin
      prio_d   = PRIO_A;
      sel_addr = bus.b_addr;
      sel_data = bus.b_data;
    end
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  // Registered write port; address/data hold when idle, r0 writes optionally suppressed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      wa_q   <= '0;
      data_q <= '0;
    end else begin
      we_q <= (grant_a || grant_b) && (R0_WRITABLE || (sel_addr != '0));
      if (grant_a || grant_b) begin
        wa_q   <= sel_addr;
        data_q <= sel_data;
      end
    end
  end

  assign bus.rf_we   = we_q;
  assign bus.rf_wa   = wa_q;
  assign bus.rf_data = data_q;

`ifdef RF_ARB_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of cycles where both requesters are valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.a_valid && bus.b_valid && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.conflict_cnt = cnt_q;
`else
  assign bus.conflict_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_banco_registros_arbitro.sv
// Bench for banco_registros_arbitro: per-cycle behavioural model plus directed literal checks.
// Two instances share stimulus, one with r0 writable and one with r0 write-suppressed.
module tb_banco_registros_arbitro;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  banco_registros_arbitro_if #(.AW(5), .DW(32)) bus  ();
  banco_registros_arbitro_if #(.AW(5), .DW(32)) bus0 ();

  banco_registros_arbitro #(.AW(5), .DW(32), .R0_WRITABLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  banco_registros_arbitro #(.AW(5), .DW(32), .R0_WRITABLE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  assign bus0.a_valid = bus.a_valid;
  assign bus0.a_addr  = bus.a_addr;
  assign bus0.a_data  = bus.a_data;
  assign bus0.b_valid = bus.b_valid;
  assign bus0.b_addr  = bus.b_addr;
  assign bus0.b_data  = bus.b_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RF_ARB_CONFLICT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Register file fed by the writable instance's output port
  logic [31:0] shadow [32];
  initial for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
  always @(posedge clk) if (rst_n && bus.rf_we) shadow[bus.rf_wa] <= bus.rf_data;

  // Model: which side was served last, and what the write port must show after the next edge
  bit          m_last_a;
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_data;
  int          m_cnt;

  always @(negedge clk) begin
    bit ea, eb;
    if (!rst_n) begin
      m_last_a = 1'b0; m_we = 1'b0; m_wa = '0; m_data = '0; m_cnt = 0;
      chk("rst_a_ready", 64'(bus.a_ready), 64'd0);
      chk("rst_b_ready", 64'(bus.b_ready), 64'd0);
      chk("rst_rf_we",   64'(bus.rf_we),   64'd0);
      chk("rst_rf_wa",   64'(bus.rf_wa),   64'd0);
      chk("rst_rf_data", 64'(bus.rf_data), 64'd0);
      chk("rst_cnt",     64'(bus.conflict_cnt), 64'd0);
      chk("rst_rf_we0",  64'(bus0.rf_we),  64'd0);
    end else begin
      // Contested: serve whichever side was not served most recently (A after reset)
      ea = bus.a_valid && (!bus.b_valid || !m_last_a);
      eb = bus.b_valid && !ea;
      chk("a_ready",   64'(bus.a_ready),   64'(ea));
      chk("b_ready",   64'(bus.b_ready),   64'(eb));
      chk("a_ready0",  64'(bus0.a_ready),  64'(ea));
      chk("b_ready0",  64'(bus0.b_ready),  64'(eb));
      chk("rf_we",     64'(bus.rf_we),     64'(m_we));
      chk("rf_wa",     64'(bus.rf_wa),     64'(m_wa));
      chk("rf_data",   64'(bus.rf_data),   64'(m_data));
      chk("rf_we0",    64'(bus0.rf_we),    64'(m_we && (m_wa != 5'd0)));
      chk("rf_wa0",    64'(bus0.rf_wa),    64'(m_wa));
      chk("rf_data0",  64'(bus0.rf_data),  64'(m_data));
      chk("conflict_cnt", 64'(bus.conflict_cnt), 64'(m_cnt));
      if (ea) begin
        m_we = 1'b1; m_wa = bus.a_addr; m_data = bus.a_data; m_last_a = 1'b1;
      end else if (eb) begin
        m_we = 1'b1; m_wa = bus.b_addr; m_data = bus.b_data; m_last_a = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (CNT_ON && bus.a_valid && bus.b_valid && m_cnt < 65535) m_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    repeat (3) step();
    rst_n = 1'b1;

    // Contention straight after reset: A,B,A,B with writes one cycle late
    bus.a_valid = 1'b1; bus.a_addr = 5'd1; bus.a_data = 32'd11;
    bus.b_valid = 1'b1; bus.b_addr = 5'd2; bus.b_data = 32'd22;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lit_cont_a_ready", 64'(bus.a_ready), 64'((i % 2) == 0));
      chk("lit_cont_b_ready", 64'(bus.b_ready), 64'((i % 2) == 1));
      chk("lit_cont_we", 64'(bus.rf_we), 64'(i > 0));
      if (i > 0) chk("lit_cont_wa", 64'(bus.rf_wa), ((i % 2) == 1) ? 64'd1 : 64'd2);
      step();
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    @(negedge clk);
    chk("lit_cont_last_we",   64'(bus.rf_we),   64'd1);
    chk("lit_cont_last_wa",   64'(bus.rf_wa),   64'd2);
    chk("lit_cont_last_data", 64'(bus.rf_data), 64'd22);
    chk("lit_cont_cnt", 64'(bus.conflict_cnt), CNT_ON ? 64'd4 : 64'd0);

    // Single A write
    step();
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("lit_single_ready", 64'(bus.a_ready), 64'd1);
    step();
    bus.a_valid = 1'b0;
    @(negedge clk);
    chk("lit_single_we",   64'(bus.rf_we),   64'd1);
    chk("lit_single_wa",   64'(bus.rf_wa),   64'd5);
    chk("lit_single_data", 64'(bus.rf_data), 64'hDEADBEEF);
    step();
    @(negedge clk);
    chk("lit_single_idle", 64'(bus.rf_we), 64'd0);

    // B write hands priority back to A
    step();
    bus.b_valid = 1'b1; bus.b_addr = 5'd4; bus.b_data = 32'd44;
    step();
    bus.b_valid = 1'b0;

    // Same address on both sides: A first, then B, last writer wins
    bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 32'd1;
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 32'd2;
    @(negedge clk);
    chk("lit_same_a_ready", 64'(bus.a_ready), 64'd1);
    chk("lit_same_b_ready", 64'(bus.b_ready), 64'd0);
    step();
    bus.a_valid = 1'b0;
    @(negedge clk);
    chk("lit_same_b_ready2", 64'(bus.b_ready), 64'd1);
    chk("lit_same_data1",    64'(bus.rf_data), 64'd1);
    step();
    bus.b_valid = 1'b0;
    @(negedge clk);
    chk("lit_same_data2", 64'(bus.rf_data), 64'd2);
    step();
    chk("lit_same_reg7", 64'(shadow[7]), 64'd2);

    // Register 0
    bus.b_valid = 1'b1; bus.b_addr = 5'd0; bus.b_data = 32'd9;
    @(negedge clk);
    chk("lit_r0_b_ready",  64'(bus0.b_ready), 64'd1);
    step();
    bus.b_valid = 1'b0;
    @(negedge clk);
    chk("lit_r0_we_wr",   64'(bus.rf_we),  64'd1);
    chk("lit_r0_wa_wr",   64'(bus.rf_wa),  64'd0);
    chk("lit_r0_we_nowr", 64'(bus0.rf_we), 64'd0);

    // Reset asserted while a write is in flight
    step();
    bus.a_valid = 1'b1; bus.a_addr = 5'd6; bus.a_data = 32'd66;
    step();
    bus.a_addr = 5'd3; bus.a_data = 32'd33;
    chk("lit_rst_inflight", 64'(bus.rf_we), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("lit_rst_we",      64'(bus.rf_we),   64'd0);
    chk("lit_rst_wa",      64'(bus.rf_wa),   64'd0);
    chk("lit_rst_data",    64'(bus.rf_data), 64'd0);
    chk("lit_rst_a_ready", 64'(bus.a_ready), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit_rel_a_ready", 64'(bus.a_ready), 64'd1);
    step();
    bus.a_valid = 1'b0;
    @(negedge clk);
    chk("lit_rel_we",   64'(bus.rf_we),   64'd1);
    chk("lit_rel_wa",   64'(bus.rf_wa),   64'd3);
    chk("lit_rel_data", 64'(bus.rf_data), 64'd33);
    chk("lit_rel_reg6", 64'(shadow[6]),   64'd0);

    // Long contention: counter saturates without wrapping
    step();
    bus.a_valid = 1'b1; bus.a_addr = 5'd10; bus.a_data = 32'd1;
    bus.b_valid = 1'b1; bus.b_addr = 5'd11; bus.b_data = 32'd2;
    repeat (70000) step();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    @(negedge clk);
    chk("lit_sat_cnt", 64'(bus.conflict_cnt), CNT_ON ? 64'hFFFF : 64'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
